// File: rtl/control_hazard.sv
// Branch/stop hazard controller for a simple in-order fetch/decode pipeline.
// Moore FSM gates fetch, selects the branch target and squashes IR2; also counts branch-stall cycles.
module control_hazard #(
  parameter int unsigned BR_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] id_opcode,
  input  logic       id_valid,
  input  logic       ex_resolve,
  input  logic       ex_taken,
  output logic       en_fetch,
  output logic       branch,
  output logic       squash,
  output logic       halted,
  output logic [7:0] stall_cycles
);

  localparam logic [2:0] ST_START    = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_BR_WAIT  = 3'd2;
  localparam logic [2:0] ST_REDIRECT = 3'd3;
  localparam logic [2:0] ST_HALT     = 3'd4;

  localparam logic [3:0] WAIT_INIT = 4'(BR_LAT - 1);

  logic [2:0] state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       is_branch, is_stop;

  assign is_branch = id_valid && (id_opcode == 4'b0101 || id_opcode == 4'b1001 ||
                                  id_opcode == 4'b1101);
  assign is_stop   = id_valid && (id_opcode == 4'b0001);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_START: state_nxt = ST_RUN;
      ST_RUN: begin
        if (is_branch) begin
          state_nxt    = ST_BR_WAIT;
          wait_cnt_nxt = WAIT_INIT;
        end else if (is_stop) begin
          state_nxt = ST_HALT;
        end
      end
      ST_BR_WAIT: begin
        // A resolve only counts once the minimum latency has elapsed.
        if (wait_cnt == 4'd0) begin
          if (ex_resolve) state_nxt = ex_taken ? ST_REDIRECT : ST_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_REDIRECT: state_nxt = ST_RUN;
      ST_HALT:     state_nxt = ST_HALT;
      default:     state_nxt = ST_START;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_START;
      wait_cnt     <= 4'd0;
      stall_cycles <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == ST_BR_WAIT && stall_cycles != 8'hFF)
        stall_cycles <= stall_cycles + 8'd1;
    end
  end

  // Outputs are a pure decode of the state register.
  always_comb begin
    en_fetch = 1'b0;
    branch   = 1'b0;
    squash   = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_RUN:      en_fetch = 1'b1;
      ST_BR_WAIT:  squash   = 1'b1;
      ST_REDIRECT: begin
        en_fetch = 1'b1;
        branch   = 1'b1;
        squash   = 1'b1;
      end
      ST_HALT: begin
        squash = 1'b1;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_hazard.md
# control_hazard

Pipeline hazard controller that drives the fetch stage's `en_fetch` and `branch` inputs. It watches the opcode in decode (IR2) and the branch resolution from execute. It stalls fetch while a branch is unresolved, redirects the PC and squashes the wrong-path instruction on a taken branch, and freezes fetch permanently on `stop`. It also keeps a saturating count of branch-stall cycles for debug.

## Interface
Parameters:
- `BR_LAT`, default 2: minimum number of stall cycles before a branch may resolve; legal range 1..15.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_opcode`  in  4  opcode of the instruction in decode (IR2).
- `id_valid`  in  1  IR2 holds a real instruction, not a bubble.
- `ex_resolve`  in  1  execute stage has evaluated the branch condition this cycle.
- `ex_taken`  in  1  branch condition true; sampled only when `ex_resolve`=1.
- `en_fetch`  out  1  fetch enable, which allows the PC to update.
- `branch`  out  1  selects the branch target for the PC (PCSel).
- `squash`  out  1  loads a bubble into IR2 instead of IR1's contents.
- `halted`  out  1  processor has stopped.
- `stall_cycles`  out  8  saturating count of BR_WAIT cycles.

## Operation
- Branch opcodes are 4'b0101, 4'b1001 and 4'b1101. Stop is 4'b0001. All other opcodes count as ordinary instructions.
- Moore FSM. `en_fetch`, `branch`, `squash` and `halted` are decoded from the state register only. They never depend combinationally on inputs.
- START: en_fetch=0, branch=0, squash=0, halted=0.
  - Always goes to RUN on the next cycle.
- RUN: en_fetch=1, branch=0, squash=0.
  - If `id_valid` and the opcode is a branch: go to BR_WAIT and load `wait_cnt` with BR_LAT-1.
  - Else if `id_valid` and the opcode is stop: go to HALT.
  - Otherwise stay in RUN.
  - The instruction fetched during the detection cycle is the fall-through instruction. It stays in IR1.
- BR_WAIT: en_fetch=0, branch=0, squash=1.
  - `wait_cnt` decrements each cycle and holds at 0.
  - Exit only when `wait_cnt`==0 and `ex_resolve`=1:
    - `ex_taken`=1: go to REDIRECT.
    - `ex_taken`=0: go to RUN, keeping the fall-through instruction in IR1.
  - `ex_resolve` while `wait_cnt`!=0 is ignored. The unit remains in BR_WAIT until a resolve arrives with `wait_cnt`==0.
- REDIRECT: en_fetch=1, branch=1, squash=1.
  - Lasts exactly one cycle, then goes to RUN.
  - Kills the fall-through instruction in IR1.
  - `id_opcode` is ignored in this state.
- HALT: en_fetch=0, branch=0, squash=1, halted=1.
  - Stays in HALT until reset.
- `stall_cycles` increments by 1 for each cycle spent in BR_WAIT and saturates at 255. It never wraps.
- `wait_cnt` is 4 bits wide and unsigned.

## Timing
- Reset values: state=START, `wait_cnt`=0, `stall_cycles`=0. Outputs while in START are en_fetch=0, branch=0, squash=0, halted=0.
- Reset has priority over every transition in every state. Asserting reset mid-BR_WAIT, mid-REDIRECT or in HALT returns the unit to START on the next edge and clears both counters.
- First fetch occurs 2 cycles after the reset edge: START, then RUN.
- Not-taken branch: RUN, then BR_LAT cycles of BR_WAIT, then RUN. Fetch is stalled for BR_LAT cycles.
- Taken branch: RUN, then BR_LAT cycles of BR_WAIT, then 1 cycle of REDIRECT, then RUN. The branch penalty is BR_LAT+1 cycles.
- A late `ex_resolve` extends BR_WAIT one cycle at a time. Each of those cycles also increments `stall_cycles`.
- A branch or stop in IR2 on the RUN cycle directly after REDIRECT or BR_WAIT is handled normally. Back-to-back branches are legal.

## Test plan
- Reset, then `id_valid`=0 throughout: cycle 1 after reset has en_fetch=0; cycles 2..20 have en_fetch=1, branch=0, squash=0; `stall_cycles`=0.
- BR_LAT=2, branch 4'b0101 in decode, `ex_resolve`=1 and `ex_taken`=0 on the second BR_WAIT cycle: en_fetch goes 1,0,0,1; branch stays 0; `stall_cycles`=2.
- BR_LAT=2, branch 4'b1001 in decode, resolved taken: one REDIRECT cycle with en_fetch=1, branch=1, squash=1, then RUN; `stall_cycles`=2.
- BR_LAT=2, `ex_resolve` first asserted 5 cycles after BR_WAIT entry, taken: 5 BR_WAIT cycles, then REDIRECT; an early `ex_resolve` pulse while `wait_cnt`=1 is ignored; `stall_cycles`=5.
- Stop 4'b0001 in decode: halted=1 and en_fetch=0 on the next cycle, held for 50 cycles; then reset gives START and halted=0.
- Reset asserted during the first BR_WAIT cycle: next state is START with `stall_cycles`=0. Separately, more than 255 BR_WAIT cycles: `stall_cycles` holds at 255.
